// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO controller slice.
// Pointer widths up to 9 bits cover every legal DEPTH (2..256).
package fifo_pkg;

  localparam int FIFO_DEPTH_DEF = 8;
  localparam int PTR_W_MAX      = 9;

  // Occupancy from wrapping pointers: difference taken modulo 2**(aw+1).
  function automatic logic [PTR_W_MAX-1:0] ptr_to_count(
    input logic [PTR_W_MAX-1:0] wr_ptr,
    input logic [PTR_W_MAX-1:0] rd_ptr,
    input int                   aw
  );
    logic [PTR_W_MAX-1:0] mask_v;
    mask_v = (9'd1 << (aw + 1)) - 9'd1;
    return (wr_ptr - rd_ptr) & mask_v;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping W-bit pointer register with increment enable.
// The top bit acts as the lap marker for full/empty detection.
module fifo_ptr import fifo_pkg::*; #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_r;

  // Pointer advances by one on each accepted operation, wrapping naturally.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ptr_r <= '0;
    end else if (inc) begin
      ptr_r <= ptr_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/fifo_ctrl.sv
// Control for a register-bank FIFO: one-hot write enables, show-ahead read
// select, and status derived purely from the write/read pointers.
module fifo_ctrl import fifo_pkg::*; #(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [DEPTH-1:0] reg_en,
  output logic [AW-1:0]    rd_sel,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  logic [AW:0]          wr_ptr_s;
  logic [AW:0]          rd_ptr_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 wr_ok_s;
  logic                 rd_ok_s;
  logic [DEPTH-1:0]     reg_en_s;
  logic [PTR_W_MAX-1:0] count_full_s;
  logic                 overflow_r;
  logic                 underflow_r;

  assign empty_s = (wr_ptr_s == rd_ptr_s);
  assign full_s  = (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]) &&
                   (wr_ptr_s[AW] != rd_ptr_s[AW]);

  // Qualified by rst_ so no enable can leak out while reset is held.
  assign wr_ok_s = wr_en && !full_s && rst_;
  assign rd_ok_s = rd_en && !empty_s && rst_;

  fifo_ptr #(.W(AW + 1)) u_wr_ptr (
    .clk  (clk),
    .rst_ (rst_),
    .inc  (wr_ok_s),
    .ptr  (wr_ptr_s)
  );

  fifo_ptr #(.W(AW + 1)) u_rd_ptr (
    .clk  (clk),
    .rst_ (rst_),
    .inc  (rd_ok_s),
    .ptr  (rd_ptr_s)
  );

  // One-hot write enable for the slot addressed by the write pointer.
  always_comb begin
    reg_en_s = '0;
    if (wr_ok_s) begin
      reg_en_s[wr_ptr_s[AW-1:0]] = 1'b1;
    end else begin
      reg_en_s = '0;
    end
  end

  assign count_full_s = ptr_to_count(PTR_W_MAX'(wr_ptr_s), PTR_W_MAX'(rd_ptr_s), AW);

  // Rejected-request pulses, registered so they appear the cycle after the edge.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= wr_en && full_s;
      underflow_r <= rd_en && empty_s;
    end
  end

  assign reg_en    = reg_en_s;
  assign rd_sel    = rd_ptr_s[AW-1:0];
  assign full      = full_s;
  assign empty     = empty_s;
  assign count     = count_full_s[AW:0];
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl at DEPTH=8.
module tb_fifo_ctrl;

  logic       clk;
  logic       rst_;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] reg_en;
  logic [2:0] rd_sel;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int checks;
  int failures;

  fifo_ctrl #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .reg_en    (reg_en),
    .rd_sel    (rd_sel),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_  = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    tick();
    rst_ = 1'b1;
  endtask

  task automatic test_reset();
    rst_  = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    #3;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (rd_sel !== 3'd0) begin failures++; $display("FAIL reset_rd_sel got=%0d exp=0", rd_sel); end
    checks++; if (reg_en !== 8'h00) begin failures++; $display("FAIL reset_reg_en got=%h exp=00", reg_en); end
    tick();
    rst_ = 1'b1;
    tick();
    checks++; if (empty !== 1'b1 || count !== 4'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset empty=%b count=%0d ovf=%b unf=%b exp 1/0/0/0", empty, count, overflow, underflow);
    end
  endtask

  task automatic test_fill();
    logic [7:0] exp_en;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      exp_en = 8'h01 << i;
      #1;
      checks++; if (reg_en !== exp_en) begin failures++; $display("FAIL fill_reg_en[%0d] got=%h exp=%h", i, reg_en, exp_en); end
      tick();
      checks++; if (count !== 4'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
      checks++; if (full !== (i == 7)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 7)); end
    end
    wr_en = 1'b1;
    #1;
    checks++; if (reg_en !== 8'h00) begin failures++; $display("FAIL overflow_reg_en got=%h exp=00", reg_en); end
    tick();
    wr_en = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_pulse got=%b exp=1", overflow); end
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL overflow_count got=%0d exp=8", count); end
    tick();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      #1;
      checks++; if (rd_sel !== 3'(i)) begin failures++; $display("FAIL drain_rd_sel[%0d] got=%0d exp=%0d", i, rd_sel, i); end
      tick();
      checks++; if (count !== 4'(7 - i)) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 7 - i); end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
    rd_en = 1'b1;
    #1;
    checks++; if (rd_sel !== 3'd0) begin failures++; $display("FAIL underflow_rd_sel got=%0d exp=0", rd_sel); end
    tick();
    rd_en = 1'b0;
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL underflow_pulse got=%b exp=1", underflow); end
    checks++; if (rd_sel !== 3'd0 || count !== 4'd0) begin failures++; $display("FAIL underflow_state rd_sel=%0d count=%0d exp 0/0", rd_sel, count); end
    tick();
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL underflow_clear got=%b exp=0", underflow); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_en;
    do_reset();
    wr_en = 1'b1;
    repeat (3) tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    repeat (2) tick();
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL b2b_start_count got=%0d exp=1", count); end
    for (int k = 0; k < 10; k++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      exp_en = 8'h01 << ((3 + k) % 8);
      #1;
      checks++; if (reg_en !== exp_en) begin failures++; $display("FAIL b2b_reg_en[%0d] got=%h exp=%h", k, reg_en, exp_en); end
      checks++; if (rd_sel !== 3'((2 + k) % 8)) begin failures++; $display("FAIL b2b_rd_sel[%0d] got=%0d exp=%0d", k, rd_sel, (2 + k) % 8); end
      tick();
      checks++; if (count !== 4'd1 || overflow !== 1'b0 || underflow !== 1'b0) begin
        failures++; $display("FAIL b2b_state[%0d] count=%0d ovf=%b unf=%b exp 1/0/0", k, count, overflow, underflow);
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_simul_edges();
    do_reset();
    wr_en = 1'b1;
    rd_en = 1'b1;
    #1;
    checks++; if (reg_en !== 8'h01) begin failures++; $display("FAIL empty_simul_reg_en got=%h exp=01", reg_en); end
    tick();
    checks++; if (count !== 4'd1 || underflow !== 1'b1 || overflow !== 1'b0) begin
      failures++; $display("FAIL empty_simul count=%0d unf=%b ovf=%b exp 1/1/0", count, underflow, overflow);
    end
    rd_en = 1'b0;
    repeat (7) tick();
    checks++; if (count !== 4'd8 || full !== 1'b1) begin failures++; $display("FAIL refill count=%0d full=%b exp 8/1", count, full); end
    rd_en = 1'b1;
    #1;
    checks++; if (reg_en !== 8'h00) begin failures++; $display("FAIL full_simul_reg_en got=%h exp=00", reg_en); end
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    checks++; if (count !== 4'd7 || overflow !== 1'b1 || full !== 1'b0) begin
      failures++; $display("FAIL full_simul count=%0d ovf=%b full=%b exp 7/1/0", count, overflow, full);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_en = 1'b1;
    repeat (5) tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    repeat (2) tick();
    rd_en = 1'b0;
    checks++; if (rd_sel !== 3'd2 || count !== 4'd3) begin failures++; $display("FAIL pre_reset rd_sel=%0d count=%0d exp 2/3", rd_sel, count); end
    wr_en = 1'b1;
    #2;
    rst_ = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      failures++; $display("FAIL async_reset_status count=%0d empty=%b full=%b exp 0/1/0", count, empty, full);
    end
    checks++; if (rd_sel !== 3'd0 || reg_en !== 8'h00) begin
      failures++; $display("FAIL async_reset_sel rd_sel=%0d reg_en=%h exp 0/00", rd_sel, reg_en);
    end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      failures++; $display("FAIL async_reset_pulse ovf=%b unf=%b exp 0/0", overflow, underflow);
    end
    rst_ = 1'b1;
    #1;
    checks++; if (reg_en !== 8'h01) begin failures++; $display("FAIL post_reset_reg_en got=%h exp=01", reg_en); end
    tick();
    wr_en = 1'b0;
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL post_reset_count got=%0d exp=1", count); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_  = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_simul_edges();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, number of storage registers in the bank; SHALL be a power of two, 2..256.
REQ-002 Parameter AW, default $clog2(DEPTH), pointer/select width; SHALL NOT be overridden independently of DEPTH.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  write request for the current cycle.
REQ-006 rd_en  input  1  read request for the current cycle.
REQ-007 reg_en  output  DEPTH  one-hot write enables, one per storage register's en input.
REQ-008 rd_sel  output  AW  index of the oldest entry, driving the read-data mux.
REQ-009 full  output  1  bank holds DEPTH entries.
REQ-010 empty  output  1  bank holds zero entries.
REQ-011 count  output  AW+1  number of stored entries, 0..DEPTH.
REQ-012 overflow  output  1  registered one-cycle pulse: write rejected.
REQ-013 underflow  output  1  registered one-cycle pulse: read rejected.

Function
REQ-014 Write accepted (wr_ok) SHALL be wr_en && !full; read accepted (rd_ok) SHALL be rd_en && !empty, both evaluated on pre-edge state.
REQ-015 reg_en SHALL be combinational: bit wr_ptr[AW-1:0] high when wr_ok, all bits low otherwise; never more than one bit high.
REQ-016 Write and read pointers SHALL be AW+1 bits (extra wrap bit); each increments by 1 on its accepted operation, wrapping mod 2*DEPTH.
REQ-017 rd_sel SHALL equal rd_ptr[AW-1:0]; read data is valid on the mux whenever empty is low, zero-latency (show-ahead).
REQ-018 empty SHALL be high iff wr_ptr == rd_ptr; full SHALL be high iff low AW bits are equal and wrap bits differ.
REQ-019 count SHALL equal wr_ptr - rd_ptr mod 2*DEPTH, updating the cycle after each accepted operation.
REQ-020 Simultaneous wr_en and rd_en when neither full nor empty: both accepted, count unchanged, both pointers advance.
REQ-021 Simultaneous wr_en and rd_en when full: read accepted, write rejected, overflow pulses, count becomes DEPTH-1.
REQ-022 Simultaneous wr_en and rd_en when empty: write accepted, read rejected (no bypass), underflow pulses, count becomes 1.
REQ-023 overflow SHALL be high for exactly the cycle after a wr_en && full edge; underflow likewise for rd_en && empty; neither sticky.
REQ-024 Rejected operations SHALL NOT move any pointer or assert any reg_en bit.
REQ-025 X or Z on wr_en/rd_en is illegal after reset release; behaviour then is unspecified.

Reset
REQ-026 rst_ low SHALL immediately, without a clock edge, force both pointers to 0, count 0, empty 1, full 0, overflow 0, underflow 0, rd_sel 0, reg_en all 0.
REQ-027 Reset mid-operation SHALL discard all stored entries; the first accepted write after release SHALL target register 0.
REQ-028 Reset release SHALL be synchronised by the integrating top level; no internal synchroniser.

Structure
REQ-029 Shared package fifo_pkg SHALL hold the default DEPTH constant and a helper function for pointer-difference-to-count.
REQ-030 One sub-module, fifo_ptr (AW+1 bit wrapping counter with increment enable, async active-low reset), SHALL be instantiated twice (write, read).
REQ-031 Full/empty/count SHALL be derived from the pointers, not held as separate state; overflow/underflow are the only other flops.

Verification (DEPTH=8)
REQ-032 Reset then idle -> empty=1, full=0, count=0, rd_sel=0, reg_en=8'h00.
REQ-033 8 consecutive writes -> reg_en walks 8'h01..8'h80, count 1..8, full=1 after 8th; 9th write -> reg_en=8'h00, overflow pulse one cycle, count stays 8.
REQ-034 From full, 8 reads -> rd_sel 0..7, count 8..0, empty=1; 9th read -> underflow pulse, rd_sel stays 0.
REQ-035 Write 3, read 2, then 10 cycles simultaneous wr/rd -> count stays 1, pointers wrap past 7 to 0, reg_en one-hot each cycle.
REQ-036 Simultaneous wr/rd when full -> count 7, overflow=1; when empty -> count 1, underflow=1, reg_en=8'h01.
REQ-037 Write 5, assert rst_ low mid-cycle -> all outputs at reset values before next clock edge; next write asserts reg_en=8'h01.
